// File: rtl/gpu_cache_fill_ctrl_if.sv
// Fill-controller port bundle: pipeline fill requests/completions, VRAM read port, cache write ports.
// master = fill controller side, slave = pipeline/memory/cache environment side.
// Signal names follow the pixel-pipeline and VRAM port naming used elsewhere in the GPU.
interface gpu_cache_fill_ctrl_if;
    // Pixel pipeline fill requests and completions
    logic        requTexCacheUpdate;
    logic [16:0] adrTexCacheUpdate;
    logic        updateTexCacheComplete;
    logic        requClutCacheUpdate;
    logic [14:0] adrClutCacheUpdate;
    logic        updateClutCacheComplete;

    // Shared VRAM read port
    logic        o_memReq;
    logic [16:0] o_memAdr;
    logic [2:0]  o_memLen;
    logic        i_memAck;
    logic        i_memValid;
    logic [63:0] i_memData;

    // Cache write ports
    logic        o_texWrite;
    logic [16:0] o_texWrAdr;
    logic [63:0] o_texWrData;
    logic        o_clutWrite;
    logic [1:0]  o_clutWrIdx;
    logic [63:0] o_clutWrData;

    logic        o_fillBusy;

    modport master (
        input  requTexCacheUpdate, adrTexCacheUpdate,
        input  requClutCacheUpdate, adrClutCacheUpdate,
        input  i_memAck, i_memValid, i_memData,
        output updateTexCacheComplete, updateClutCacheComplete,
        output o_memReq, o_memAdr, o_memLen,
        output o_texWrite, o_texWrAdr, o_texWrData,
        output o_clutWrite, o_clutWrIdx, o_clutWrData,
        output o_fillBusy
    );

    modport slave (
        output requTexCacheUpdate, adrTexCacheUpdate,
        output requClutCacheUpdate, adrClutCacheUpdate,
        output i_memAck, i_memValid, i_memData,
        input  updateTexCacheComplete, updateClutCacheComplete,
        input  o_memReq, o_memAdr, o_memLen,
        input  o_texWrite, o_texWrAdr, o_texWrData,
        input  o_clutWrite, o_clutWrIdx, o_clutWrData,
        input  o_fillBusy
    );
endinterface

// File: rtl/gpu_cache_fill_ctrl.sv
// Tex$/CLUT$ fill arbiter: grants one miss fill at a time to VRAM, writes returned beats, pulses completion.
// Latency: request->o_memReq 1 cycle; beat->cache write 1 cycle; last beat->complete 1 cycle.
// Backpressure: o_memReq held until i_memAck; beats may arrive with gaps; pending requests wait in IDLE.
module gpu_cache_fill_ctrl (
    input  logic                         clk,
    input  logic                         i_nrst,
    gpu_cache_fill_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_owner_clut;   // 0 = Tex owns the fill, 1 = CLUT owns it
    logic [16:0] r_adr;          // latched start address, frozen until DONE
    logic [2:0]  r_len;
    logic [1:0]  r_cnt;          // beats received in the current burst
    logic        r_guard_tex;    // hides a just-completed Tex request for one IDLE cycle
    logic        r_guard_clut;

    logic        r_mem_req;
    logic        r_tex_write;
    logic [16:0] r_tex_wr_adr;
    logic [63:0] r_tex_wr_data;
    logic        r_clut_write;
    logic [1:0]  r_clut_wr_idx;
    logic [63:0] r_clut_wr_data;
    logic        r_tex_complete;
    logic        r_clut_complete;
    logic        r_fill_busy;

    logic        w_tex_req;
    logic        w_clut_req;
    logic        w_last_beat;

    // The cache hit logic lags a completion by a cycle, so a still-high level is masked once.
    assign w_tex_req   = bus.requTexCacheUpdate  & ~r_guard_tex;
    assign w_clut_req  = bus.requClutCacheUpdate & ~r_guard_clut;
    // Tex lines are a single beat; CLUT lines end on the fourth.
    assign w_last_beat = r_owner_clut ? (r_cnt == 2'd3) : 1'b1;

    // Fill sequencer: arbitration, VRAM request handshake, beat capture, completion.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state         <= S_IDLE;
            r_owner_clut    <= 1'b0;
            r_adr           <= 17'd0;
            r_len           <= 3'd0;
            r_cnt           <= 2'd0;
            r_guard_tex     <= 1'b0;
            r_guard_clut    <= 1'b0;
            r_mem_req       <= 1'b0;
            r_tex_write     <= 1'b0;
            r_tex_wr_adr    <= 17'd0;
            r_tex_wr_data   <= 64'd0;
            r_clut_write    <= 1'b0;
            r_clut_wr_idx   <= 2'd0;
            r_clut_wr_data  <= 64'd0;
            r_tex_complete  <= 1'b0;
            r_clut_complete <= 1'b0;
            r_fill_busy     <= 1'b0;
        end else begin
            // Strobes and completion pulses are single-cycle by default.
            r_tex_write     <= 1'b0;
            r_clut_write    <= 1'b0;
            r_tex_complete  <= 1'b0;
            r_clut_complete <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Guards only cover the first IDLE cycle after a completion.
                    r_guard_tex  <= 1'b0;
                    r_guard_clut <= 1'b0;
                    if (w_tex_req) begin
                        r_owner_clut <= 1'b0;
                        r_adr        <= bus.adrTexCacheUpdate;
                        r_len        <= 3'd1;
                        r_cnt        <= 2'd0;
                        r_mem_req    <= 1'b1;
                        r_fill_busy  <= 1'b1;
                        r_state      <= S_REQ;
                    end else if (w_clut_req) begin
                        r_owner_clut <= 1'b1;
                        r_adr        <= {bus.adrClutCacheUpdate, 2'b00};
                        r_len        <= 3'd4;
                        r_cnt        <= 2'd0;
                        r_mem_req    <= 1'b1;
                        r_fill_busy  <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Data in the ack cycle itself is not captured: capture starts in DATA.
                    if (bus.i_memAck) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bus.i_memValid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_owner_clut) begin
                            r_clut_write   <= 1'b1;
                            r_clut_wr_idx  <= r_cnt;
                            r_clut_wr_data <= bus.i_memData;
                        end else begin
                            r_tex_write    <= 1'b1;
                            r_tex_wr_adr   <= r_adr;
                            r_tex_wr_data  <= bus.i_memData;
                        end
                        // Completion pulse lines up with the final write strobe.
                        if (w_last_beat) begin
                            r_tex_complete  <= ~r_owner_clut;
                            r_clut_complete <= r_owner_clut;
                            r_state         <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_guard_tex  <= ~r_owner_clut;
                    r_guard_clut <= r_owner_clut;
                    r_fill_busy  <= 1'b0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_mem_req   <= 1'b0;
                    r_fill_busy <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign bus.o_memReq                = r_mem_req;
    assign bus.o_memAdr                = r_adr;
    assign bus.o_memLen                = r_len;
    assign bus.o_texWrite              = r_tex_write;
    assign bus.o_texWrAdr              = r_tex_wr_adr;
    assign bus.o_texWrData             = r_tex_wr_data;
    assign bus.o_clutWrite             = r_clut_write;
    assign bus.o_clutWrIdx             = r_clut_wr_idx;
    assign bus.o_clutWrData            = r_clut_wr_data;
    assign bus.updateTexCacheComplete  = r_tex_complete;
    assign bus.updateClutCacheComplete = r_clut_complete;
    assign bus.o_fillBusy              = r_fill_busy;

endmodule

// File: tb/tb_gpu_cache_fill_ctrl.sv
// Directed bench for gpu_cache_fill_ctrl: Tex fill, CLUT fill with gaps, arbitration/guard, stray beats, mid-burst reset.
// Outputs are sampled 1 time unit after each rising edge; inputs are changed at that same point.
// Each comparison is an immediate assertion; failures are counted and reported.
module tb_gpu_cache_fill_ctrl;

    logic clk;
    logic i_nrst;
    int   checks;
    int   failures;

    gpu_cache_fill_ctrl_if bus();

    gpu_cache_fill_ctrl dut (
        .clk    (clk),
        .i_nrst (i_nrst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".memReq"},      64'(bus.o_memReq),                0);
        chk({tag, ".memAdr"},      64'(bus.o_memAdr),                0);
        chk({tag, ".memLen"},      64'(bus.o_memLen),                0);
        chk({tag, ".texWrite"},    64'(bus.o_texWrite),              0);
        chk({tag, ".texWrAdr"},    64'(bus.o_texWrAdr),              0);
        chk({tag, ".texWrData"},   bus.o_texWrData,                  0);
        chk({tag, ".clutWrite"},   64'(bus.o_clutWrite),             0);
        chk({tag, ".clutWrIdx"},   64'(bus.o_clutWrIdx),             0);
        chk({tag, ".clutWrData"},  bus.o_clutWrData,                 0);
        chk({tag, ".texCmpl"},     64'(bus.updateTexCacheComplete),  0);
        chk({tag, ".clutCmpl"},    64'(bus.updateClutCacheComplete), 0);
        chk({tag, ".busy"},        64'(bus.o_fillBusy),              0);
    endtask

    logic [63:0] clut_beats [4];

    initial begin
        checks   = 0;
        failures = 0;
        i_nrst   = 1'b0;
        bus.requTexCacheUpdate  = 1'b0;
        bus.adrTexCacheUpdate   = 17'd0;
        bus.requClutCacheUpdate = 1'b0;
        bus.adrClutCacheUpdate  = 15'd0;
        bus.i_memAck   = 1'b0;
        bus.i_memValid = 1'b0;
        bus.i_memData  = 64'd0;
        clut_beats[0] = 64'h1111_2222_3333_4444;
        clut_beats[1] = 64'h5555_6666_7777_8888;
        clut_beats[2] = 64'h9999_AAAA_BBBB_CCCC;
        clut_beats[3] = 64'hDDDD_EEEE_FFFF_0001;

        // ---------------- reset state ----------------
        step();
        step();
        chk_all_zero("reset");
        i_nrst = 1'b1;
        step();

        // ---------------- Tex fill ----------------
        bus.requTexCacheUpdate = 1'b1;                  // cycle N
        bus.adrTexCacheUpdate  = 17'h1ABCD;
        step();                                         // N+1: REQ
        chk("tex.memReq", 64'(bus.o_memReq), 1);
        chk("tex.memAdr", 64'(bus.o_memAdr), 64'h1ABCD);
        chk("tex.memLen", 64'(bus.o_memLen), 1);
        chk("tex.busy",   64'(bus.o_fillBusy), 1);
        step();                                         // N+2: ack, stray beat in ack cycle
        chk("tex.memReqHeld", 64'(bus.o_memReq), 1);
        bus.i_memAck   = 1'b1;
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();                                         // N+3: DATA, no beat
        bus.i_memAck   = 1'b0;
        bus.i_memValid = 1'b0;
        bus.adrTexCacheUpdate = 17'h00000;              // address change mid-fill must not matter
        chk("tex.memReqDropped",   64'(bus.o_memReq), 0);
        chk("tex.noWriteAckCycle", 64'(bus.o_texWrite), 0);
        step();                                         // N+4: beat
        chk("tex.noWriteYet", 64'(bus.o_texWrite), 0);
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'h0123_4567_89AB_CDEF;
        step();                                         // N+5: write + complete
        bus.i_memValid = 1'b0;
        bus.requTexCacheUpdate = 1'b0;
        chk("tex.write",   64'(bus.o_texWrite), 1);
        chk("tex.wrAdr",   64'(bus.o_texWrAdr), 64'h1ABCD);
        chk("tex.wrData",  bus.o_texWrData, 64'h0123_4567_89AB_CDEF);
        chk("tex.cmpl",    64'(bus.updateTexCacheComplete), 1);
        chk("tex.noClutCmpl", 64'(bus.updateClutCacheComplete), 0);
        step();                                         // N+6: IDLE, stray beat in IDLE
        chk("tex.writeOnce", 64'(bus.o_texWrite), 0);
        chk("tex.cmplOnce",  64'(bus.updateTexCacheComplete), 0);
        chk("tex.idleBusy",  64'(bus.o_fillBusy), 0);
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        bus.i_memValid = 1'b0;
        chk("stray.texWrite",  64'(bus.o_texWrite), 0);
        chk("stray.clutWrite", 64'(bus.o_clutWrite), 0);
        chk("stray.busy",      64'(bus.o_fillBusy), 0);
        chk("stray.memReq",    64'(bus.o_memReq), 0);

        // ---------------- CLUT fill with gaps ----------------
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = 15'h7FC1;
        step();
        chk("clut.memReq", 64'(bus.o_memReq), 1);
        chk("clut.memAdr", 64'(bus.o_memAdr), 64'h1FF04);
        chk("clut.memLen", 64'(bus.o_memLen), 4);
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck = 1'b0;
        chk("clut.memReqDropped", 64'(bus.o_memReq), 0);
        for (int b = 0; b < 4; b++) begin
            bus.i_memValid = 1'b1;
            bus.i_memData  = clut_beats[b];
            step();
            bus.i_memValid = 1'b0;
            chk($sformatf("clut.write%0d", b), 64'(bus.o_clutWrite), 1);
            chk($sformatf("clut.idx%0d", b),   64'(bus.o_clutWrIdx), 64'(b));
            chk($sformatf("clut.data%0d", b),  bus.o_clutWrData, clut_beats[b]);
            chk($sformatf("clut.cmpl%0d", b),  64'(bus.updateClutCacheComplete), (b == 3) ? 64'd1 : 64'd0);
            chk($sformatf("clut.noTex%0d", b), 64'(bus.o_texWrite), 0);
            if (b == 3) bus.requClutCacheUpdate = 1'b0;
            step();                                     // gap cycle
            chk($sformatf("clut.gapWrite%0d", b), 64'(bus.o_clutWrite), 0);
            chk($sformatf("clut.gapCmpl%0d", b),  64'(bus.updateClutCacheComplete), 0);
        end
        chk("clut.idleBusy", 64'(bus.o_fillBusy), 0);

        // ---------------- simultaneous requests, guard ----------------
        bus.requTexCacheUpdate  = 1'b1;                 // cycle P
        bus.adrTexCacheUpdate   = 17'h00123;
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = 15'h0042;
        step();                                         // P+1
        chk("arb.texFirstAdr", 64'(bus.o_memAdr), 64'h00123);
        chk("arb.texFirstLen", 64'(bus.o_memLen), 1);
        bus.i_memAck = 1'b1;
        step();                                         // P+2 (L)
        bus.i_memAck   = 1'b0;
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'hCAFE_F00D_0000_0001;
        step();                                         // L+1
        bus.i_memValid = 1'b0;
        chk("arb.texWrite", 64'(bus.o_texWrite), 1);
        chk("arb.texCmpl",  64'(bus.updateTexCacheComplete), 1);
        step();                                         // L+2: IDLE, Tex still high but masked
        chk("arb.idleReq",  64'(bus.o_memReq), 0);
        chk("arb.idleBusy", 64'(bus.o_fillBusy), 0);
        step();                                         // L+3: CLUT granted
        bus.requTexCacheUpdate = 1'b0;
        chk("arb.clutReq", 64'(bus.o_memReq), 1);
        chk("arb.clutAdr", 64'(bus.o_memAdr), 64'h00108);
        chk("arb.clutLen", 64'(bus.o_memLen), 4);
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.i_memValid = 1'b1;
            bus.i_memData  = 64'(b) + 64'hA0;
            step();
            chk($sformatf("arb.b2bIdx%0d", b),  64'(bus.o_clutWrIdx), 64'(b));
            chk($sformatf("arb.b2bData%0d", b), bus.o_clutWrData, 64'(b) + 64'hA0);
        end
        bus.i_memValid = 1'b0;
        chk("arb.b2bCmpl", 64'(bus.updateClutCacheComplete), 1);
        bus.requClutCacheUpdate = 1'b0;
        step();
        step();
        chk("arb.endBusy", 64'(bus.o_fillBusy), 0);

        // ---------------- reset mid CLUT burst ----------------
        bus.requClutCacheUpdate = 1'b1;
        bus.adrClutCacheUpdate  = 15'h1234;
        step();
        chk("rst.memAdr", 64'(bus.o_memAdr), 64'h048D0);
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck   = 1'b0;
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'h0000_0000_0000_00B0;
        step();
        chk("rst.beat0Idx", 64'(bus.o_clutWrIdx), 0);
        bus.i_memData = 64'h0000_0000_0000_00B1;
        step();
        bus.i_memValid = 1'b0;
        chk("rst.beat1Idx",   64'(bus.o_clutWrIdx), 1);
        chk("rst.beat1Write", 64'(bus.o_clutWrite), 1);
        i_nrst = 1'b0;
        bus.requClutCacheUpdate = 1'b0;
        #1;
        chk_all_zero("rstAsync");
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'h0000_0000_0000_00B2;
        step();
        chk("rst.lateBeatHeld", 64'(bus.o_clutWrite), 0);
        i_nrst = 1'b1;
        bus.i_memData = 64'h0000_0000_0000_00B3;
        step();
        bus.i_memValid = 1'b0;
        chk("rst.lateBeatAfter", 64'(bus.o_clutWrite), 0);
        chk("rst.lateBusy",      64'(bus.o_fillBusy), 0);
        chk("rst.lateCmpl",      64'(bus.updateClutCacheComplete), 0);

        bus.requTexCacheUpdate = 1'b1;
        bus.adrTexCacheUpdate  = 17'h0F0F0;
        step();
        chk("post.memReq", 64'(bus.o_memReq), 1);
        chk("post.memAdr", 64'(bus.o_memAdr), 64'h0F0F0);
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck   = 1'b0;
        bus.i_memValid = 1'b1;
        bus.i_memData  = 64'h7777_0000_1234_5678;
        step();
        bus.i_memValid = 1'b0;
        bus.requTexCacheUpdate = 1'b0;
        chk("post.texWrite", 64'(bus.o_texWrite), 1);
        chk("post.texAdr",   64'(bus.o_texWrAdr), 64'h0F0F0);
        chk("post.texData",  bus.o_texWrData, 64'h7777_0000_1234_5678);
        chk("post.texCmpl",  64'(bus.updateTexCacheComplete), 1);
        step();
        chk("post.idleBusy", 64'(bus.o_fillBusy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
